mem_miss_ctrl: RTL

//  Initiator-side controller for the line-granular memory port (req/we/addr/wdata -> gnt/rvalid/rdata).

---
 rtl/mem_miss_ctrl_pkg.sv | 17 +
 rtl/mem_miss_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mem_miss_ctrl_pkg.sv
// Shared constants and state encoding for the cache miss controller.
// The line geometry here gives the default parameter values used by mem_miss_ctrl.
package mem_miss_ctrl_pkg;

  localparam int LINE_BYTES = 16;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int OFFSET_W   = $clog2(LINE_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    RD_REQ,
    RD_WAIT,
    RESP
  } miss_state_t;

endpackage

// File: rtl/mem_miss_ctrl.sv
// Services one cache miss at a time: optional dirty-victim write-back, line read,
// then hands the fetched line back to the cache over a valid/ready handshake.
module mem_miss_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = mem_miss_ctrl_pkg::LINE_BYTES,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    miss_req,
  output logic                    miss_ready,
  input  logic [ADDR_WIDTH-1:0]   miss_addr,
  input  logic                    miss_wb,
  input  logic [ADDR_WIDTH-1:0]   miss_wb_addr,
  input  logic [LINE_BYTES*8-1:0] miss_wb_data,
  output logic                    fill_valid,
  input  logic                    fill_ready,
  output logic [ADDR_WIDTH-1:0]   fill_addr,
  output logic [LINE_BYTES*8-1:0] fill_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [LINE_BYTES*8-1:0] mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [LINE_BYTES*8-1:0] mem_rdata,
  output logic                    err_timeout,
  output logic                    err_unexp
);

  import mem_miss_ctrl_pkg::*;

  localparam int LW     = LINE_BYTES * 8;
  localparam int OFFS   = $clog2(LINE_BYTES);
  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  miss_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [LW-1:0]         wb_data_q, wb_data_d;
  logic [LW-1:0]         data_q, data_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic                  err_timeout_q, err_timeout_d;
  logic                  err_unexp_q, err_unexp_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    addr_d        = addr_q;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    data_d        = data_q;
    wdog_d        = wdog_q;
    err_timeout_d = err_timeout_q;
    err_unexp_d   = err_unexp_q;

    // A response is only legal while a read is outstanding; anything else is flagged and dropped.
    if (mem_rvalid && state_q != RD_WAIT) begin
      err_unexp_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (miss_req) begin
          addr_d    = {miss_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
          wb_addr_d = {miss_wb_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
          wb_data_d = miss_wb_data;
          state_d   = miss_wb ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        // Writes have no acknowledge; in-order memory makes the following read see this data.
        if (mem_gnt) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_gnt) begin
          wdog_d  = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (mem_rvalid) begin
          data_d  = mem_rdata;
          state_d = RESP;
        end else if (wdog_d == WDOG_W'(TIMEOUT)) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end
      RESP: begin
        if (fill_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      data_q        <= '0;
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
      err_unexp_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      data_q        <= data_d;
      wdog_q        <= wdog_d;
      err_timeout_q <= err_timeout_d;
      err_unexp_q   <= err_unexp_d;
    end
  end

  // Memory-side outputs decode registered state only, so they stay stable until granted.
  assign miss_ready  = (state_q == IDLE);
  assign mem_req     = (state_q == WB_REQ) || (state_q == RD_REQ);
  assign mem_we      = (state_q == WB_REQ);
  assign mem_addr    = (state_q == WB_REQ) ? wb_addr_q : addr_q;
  assign mem_wdata   = wb_data_q;
  assign fill_valid  = (state_q == RESP);
  assign fill_addr   = addr_q;
  assign fill_data   = data_q;
  assign err_timeout = err_timeout_q;
  assign err_unexp   = err_unexp_q;

endmodule
